// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the writeback arbiter's pipeline, issue, result, hazard-check and
// register-file write signals.
interface regfile_wb_arbiter_if;
  logic        p_we;
  logic [4:0]  p_wn;
  logic [31:0] p_d;
  logic        iss_valid;
  logic [4:0]  iss_wn;
  logic        iss_ready;
  logic        m_valid;
  logic [4:0]  m_wn;
  logic [31:0] m_d;
  logic        m_ready;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [4:0]  rnw;
  logic        busy_a;
  logic        busy_b;
  logic        busy_w;
  logic        stall_req;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;

  modport master (
    output p_we, p_wn, p_d, iss_valid, iss_wn, m_valid, m_wn, m_d, rna, rnb, rnw,
    input  iss_ready, m_ready, busy_a, busy_b, busy_w, stall_req, we, wn, d
  );

  modport slave (
    input  p_we, p_wn, p_d, iss_valid, iss_wn, m_valid, m_wn, m_d, rna, rnb, rnw,
    output iss_ready, m_ready, busy_a, busy_b, busy_w, stall_req, we, wn, d
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, buffered
// long-latency results fill idle cycles, with a pending scoreboard and starvation stall.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 4
) (
  input logic                 clk,
  input logic                 clr,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [4:0]    fifo_wn_q [DEPTH];
  logic [31:0]   fifo_d_q  [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  // Bit 0 is held at zero so register 0 can be indexed directly and never reads busy.
  logic [31:0]   pending_q, pending_d;

  logic        p_valid;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        iss_ready;
  logic        iss_take;
  logic [4:0]  head_wn;
  logic [31:0] head_d;

  always_comb begin
    head_wn    = fifo_wn_q[rd_ptr_q];
    head_d     = fifo_d_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    p_valid    = !clr && bus.p_we && (bus.p_wn != '0);
    pop        = !clr && !p_valid && !fifo_empty;

    bus.m_ready   = !clr && (count_q < CW'(DEPTH));
    push          = !clr && (count_q < CW'(DEPTH)) && bus.m_valid && (bus.m_wn != '0);
    iss_ready     = !clr && !pending_q[bus.iss_wn];
    iss_take      = iss_ready && bus.iss_valid && (bus.iss_wn != '0);
    bus.iss_ready = iss_ready;
    bus.busy_a    = !clr && pending_q[bus.rna];
    bus.busy_b    = !clr && pending_q[bus.rnb];
    bus.busy_w    = !clr && pending_q[bus.rnw];
    bus.stall_req = !clr && (starve_q == SW'(STARVE_LIM));

    bus.we = 1'b0;
    bus.wn = '0;
    bus.d  = '0;
    if (p_valid) begin
      bus.we = 1'b1;
      bus.wn = bus.p_wn;
      bus.d  = bus.p_d;
    end else if (pop) begin
      bus.we = 1'b1;
      bus.wn = head_wn;
      bus.d  = head_d;
    end

    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A non-empty FIFO that does not pop this cycle is being blocked by the pipeline.
    if (fifo_empty || pop)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIM))
      starve_d = starve_q + SW'(1);
    else
      starve_d = starve_q;

    pending_d = pending_q;
    if (pop)
      pending_d[head_wn] = 1'b0;
    if (iss_take)
      pending_d[bus.iss_wn] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wn_q[wr_ptr_q] <= bus.m_wn;
      fifo_d_q[wr_ptr_q]  <= bus.m_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  wn;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] pend   = '0;
  int          starve = 0;

  logic        e_we, e_mr, e_ir, e_st, e_ba, e_bb, e_bw;
  logic [4:0]  e_wn;
  logic [31:0] e_d;

  typedef struct {
    logic        clr, p_we;
    logic [4:0]  p_wn;
    logic [31:0] p_d;
    logic        iss_valid;
    logic [4:0]  iss_wn;
    logic        m_valid;
    logic [4:0]  m_wn;
    logic [31:0] m_d;
    logic [4:0]  rna, rnb, rnw;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        mr, ir, st, ba, bb, bw;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input int c, input int pw, input int pwn, input logic [31:0] pd,
                              input int iv, input int iwn, input int mv, input int mwn,
                              input logic [31:0] md, input int ra, input int rb, input int rw,
                              input int we, input int wn, input logic [31:0] d, input int mr,
                              input int ir, input int st, input int ba, input int bb, input int bw);
    vec_t v;
    v.clr = 1'(c);   v.p_we = 1'(pw);       v.p_wn = 5'(pwn);  v.p_d = pd;
    v.iss_valid = 1'(iv); v.iss_wn = 5'(iwn); v.m_valid = 1'(mv); v.m_wn = 5'(mwn);
    v.m_d = md;      v.rna = 5'(ra);        v.rnb = 5'(rb);    v.rnw = 5'(rw);
    v.we = 1'(we);   v.wn = 5'(wn);         v.d = d;           v.mr = 1'(mr);
    v.ir = 1'(ir);   v.st = 1'(st);         v.ba = 1'(ba);     v.bb = 1'(bb);
    v.bw = 1'(bw);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    clr = 1'b0;
    bus.p_we = 1'b0; bus.p_wn = '0; bus.p_d = '0;
    bus.iss_valid = 1'b0; bus.iss_wn = '0;
    bus.m_valid = 1'b0; bus.m_wn = '0; bus.m_d = '0;
    bus.rna = '0; bus.rnb = '0; bus.rnw = '0;
  endtask

  task automatic set_in(input vec_t v);
    clr = v.clr;
    bus.p_we = v.p_we; bus.p_wn = v.p_wn; bus.p_d = v.p_d;
    bus.iss_valid = v.iss_valid; bus.iss_wn = v.iss_wn;
    bus.m_valid = v.m_valid; bus.m_wn = v.m_wn; bus.m_d = v.m_d;
    bus.rna = v.rna; bus.rnb = v.rnb; bus.rnw = v.rnw;
  endtask

  // Expected outputs from the architectural rules applied to the model state.
  task automatic model_outputs();
    e_we = 0; e_wn = '0; e_d = '0; e_mr = 0; e_ir = 0; e_st = 0;
    e_ba = 0; e_bb = 0; e_bw = 0;
    if (!clr) begin
      if (bus.p_we && bus.p_wn != 0) begin
        e_we = 1; e_wn = bus.p_wn; e_d = bus.p_d;
      end else if (mq.size() > 0) begin
        e_we = 1; e_wn = mq[0].wn; e_d = mq[0].d;
      end
      e_mr = (mq.size() < DEPTH);
      e_ir = (bus.iss_wn == 0) || !pend[bus.iss_wn];
      e_st = (starve == LIM);
      e_ba = (bus.rna != 0) && pend[bus.rna];
      e_bb = (bus.rnb != 0) && pend[bus.rnb];
      e_bw = (bus.rnw != 0) && pend[bus.rnw];
    end
  endtask

  task automatic model_update();
    bit pv, pop, accept, take;
    int n;
    if (clr) begin
      mq.delete();
      pend   = '0;
      starve = 0;
    end else begin
      n      = mq.size();
      pv     = bus.p_we && (bus.p_wn != 0);
      pop    = !pv && (n > 0);
      accept = bus.m_valid && (n < DEPTH) && (bus.m_wn != 0);
      take   = bus.iss_valid && (bus.iss_wn != 0) && !pend[bus.iss_wn];
      if (n == 0 || pop) starve = 0;
      else if (starve < LIM) starve++;
      if (pop) begin
        pend[mq[0].wn] = 1'b0;
        void'(mq.pop_front());
      end
      if (accept) mq.push_back('{bus.m_wn, bus.m_d});
      if (take) pend[bus.iss_wn] = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    model_outputs();
    chk({tag, ".we"},        bus.we,        e_we);
    chk({tag, ".wn"},        bus.wn,        e_wn);
    chk({tag, ".d"},         bus.d,         e_d);
    chk({tag, ".m_ready"},   bus.m_ready,   e_mr);
    chk({tag, ".iss_ready"}, bus.iss_ready, e_ir);
    chk({tag, ".stall_req"}, bus.stall_req, e_st);
    chk({tag, ".busy_a"},    bus.busy_a,    e_ba);
    chk({tag, ".busy_b"},    bus.busy_b,    e_bb);
    chk({tag, ".busy_w"},    bus.busy_w,    e_bw);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cands[$];
    string nm;

    tbl[0]  = mk(1,1,5,32'h1234,1,3,1,2,32'h55,  7,7,7, 0,0,0,          0,0,0,0,0,0);
    tbl[1]  = mk(0,1,5,32'h1234,0,0,0,0,0,       7,7,7, 1,5,32'h1234,   1,1,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,       1,7,0,0,0,       7,7,7, 0,0,0,          1,1,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,       0,0,1,7,32'hDEAD,7,3,7, 0,0,0,          1,1,0,1,0,1);
    tbl[4]  = mk(0,0,0,0,       0,0,0,0,0,       7,3,7, 1,7,32'hDEAD,   1,1,0,1,0,1);
    tbl[5]  = mk(0,0,0,0,       0,0,0,0,0,       7,3,7, 0,0,0,          1,1,0,0,0,0);
    tbl[6]  = mk(0,0,0,0,       1,3,0,0,0,       7,3,7, 0,0,0,          1,1,0,0,0,0);
    tbl[7]  = mk(0,0,0,0,       1,3,0,0,0,       7,3,7, 0,0,0,          1,0,0,0,1,0);
    tbl[8]  = mk(0,0,0,0,       1,0,0,0,0,       0,3,0, 0,0,0,          1,1,0,0,1,0);
    tbl[9]  = mk(0,0,0,0,       0,0,1,0,32'hBEEF,0,3,0, 0,0,0,          1,1,0,0,1,0);
    tbl[10] = mk(0,0,0,0,       0,0,0,0,0,       0,3,0, 0,0,0,          1,1,0,0,1,0);
    tbl[11] = mk(0,1,0,32'hFFFF,0,0,0,0,0,       0,3,0, 0,0,0,          1,1,0,0,1,0);

    clr = 1'b1;
    set_idle();
    clr = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    foreach (tbl[i]) begin
      set_in(tbl[i]);
      @(negedge clk);
      nm = $sformatf("tbl%0d", i);
      chk({nm, ".we"},        bus.we,        tbl[i].we);
      chk({nm, ".wn"},        bus.wn,        tbl[i].wn);
      chk({nm, ".d"},         bus.d,         tbl[i].d);
      chk({nm, ".m_ready"},   bus.m_ready,   tbl[i].mr);
      chk({nm, ".iss_ready"}, bus.iss_ready, tbl[i].ir);
      chk({nm, ".stall_req"}, bus.stall_req, tbl[i].st);
      chk({nm, ".busy_a"},    bus.busy_a,    tbl[i].ba);
      chk({nm, ".busy_b"},    bus.busy_b,    tbl[i].bb);
      chk({nm, ".busy_w"},    bus.busy_w,    tbl[i].bw);
      tick();
    end

    // FIFO fill behind a busy pipeline, starvation stall and bubble
    for (int i = 0; i < 9; i++) begin
      set_idle();
      bus.p_we = (i != 6); bus.p_wn = 5'd1; bus.p_d = 32'(i);
      bus.m_valid = (i < 3); bus.m_wn = 5'(10 + i); bus.m_d = 32'(32'hA0 + i);
      @(negedge clk);
      check_model($sformatf("starve%0d", i));
      if (i == 2) chk("full_m_ready", bus.m_ready, 0);
      if (i == 4) chk("stall_pre", bus.stall_req, 0);
      if (i == 5) chk("stall_rise", bus.stall_req, 1);
      if (i == 6) begin
        chk("bubble_we", bus.we, 1);
        chk("bubble_wn", bus.wn, 10);
        chk("bubble_d",  bus.d, 32'hA0);
      end
      if (i == 7) chk("stall_clear", bus.stall_req, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_idle();
      @(negedge clk);
      check_model($sformatf("drain%0d", i));
      tick();
    end

    // Simultaneous pop of r4 and issue of r9
    set_idle(); bus.iss_valid = 1'b1; bus.iss_wn = 5'd4;
    @(negedge clk); check_model("sim_iss4"); tick();
    set_idle(); bus.m_valid = 1'b1; bus.m_wn = 5'd4; bus.m_d = 32'h44;
    @(negedge clk); check_model("sim_push4"); tick();
    set_idle(); bus.iss_valid = 1'b1; bus.iss_wn = 5'd9; bus.rna = 5'd4; bus.rnb = 5'd9;
    @(negedge clk);
    check_model("sim_pop");
    chk("sim_pop_wn", bus.wn, 4);
    chk("sim_pop_busy4", bus.busy_a, 1);
    tick();
    set_idle(); bus.rna = 5'd4; bus.rnb = 5'd9;
    @(negedge clk);
    chk("sim_after_busy4", bus.busy_a, 0);
    chk("sim_after_busy9", bus.busy_b, 1);
    tick();

    // Reset with buffered results and pending destinations
    for (int i = 0; i < 5; i++) begin
      set_idle();
      bus.p_we = 1'b1; bus.p_wn = 5'd2; bus.p_d = 32'(i);
      if (i < 3) begin bus.iss_valid = 1'b1; bus.iss_wn = 5'(20 + i); end
      else begin bus.m_valid = 1'b1; bus.m_wn = 5'(17 + i); bus.m_d = 32'(i); end
      @(negedge clk); check_model($sformatf("clrfill%0d", i)); tick();
    end
    set_idle(); clr = 1'b1; bus.p_we = 1'b1; bus.p_wn = 5'd2;
    bus.rna = 5'd20; bus.rnb = 5'd21; bus.rnw = 5'd22;
    @(negedge clk);
    check_model("clr_active");
    chk("clr_we", bus.we, 0);
    chk("clr_m_ready", bus.m_ready, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_idle(); bus.rna = 5'd20; bus.rnb = 5'd21; bus.rnw = 5'd22;
      @(negedge clk);
      chk($sformatf("postclr%0d_we", i), bus.we, 0);
      chk($sformatf("postclr%0d_busy", i), {bus.busy_a, bus.busy_b, bus.busy_w}, 0);
      chk($sformatf("postclr%0d_m_ready", i), bus.m_ready, 1);
      tick();
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      set_idle();
      clr = ($urandom_range(0, 63) == 0);
      bus.p_we = (starve == LIM) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      bus.p_wn = 5'($urandom_range(0, 31));
      bus.p_d  = $urandom;
      bus.iss_valid = ($urandom_range(0, 2) == 0);
      bus.iss_wn = 5'($urandom_range(0, 31));
      cands.delete();
      for (int r = 1; r < 32; r++) begin
        bit inq;
        inq = 0;
        foreach (mq[k]) if (mq[k].wn == 5'(r)) inq = 1;
        if (pend[r] && !inq) cands.push_back(r);
      end
      if ($urandom_range(0, 9) == 0) begin
        bus.m_valid = 1'b1; bus.m_wn = '0;
      end else if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.m_valid = 1'b1;
        bus.m_wn = 5'(cands[$urandom_range(0, cands.size() - 1)]);
      end
      bus.m_d = $urandom;
      bus.rna = 5'($urandom_range(0, 31));
      bus.rnb = 5'($urandom_range(0, 31));
      bus.rnw = 5'($urandom_range(0, 31));
      @(negedge clk);
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
